// File: rtl/axi_rd_arbiter_2to1_if.sv
// axi_rd_arbiter_2to1_if: AXI read address and read data channel bundle
interface axi_rd_arbiter_2to1_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [3:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic [1:0]            ARBURST;
   logic [ID_WIDTH-1:0]   ARID;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic [ID_WIDTH-1:0]   RID;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;
   modport master (
      output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY,
      input  ARREADY, RDATA, RRESP, RID, RLAST, RVALID
   );
   modport slave (
      input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY,
      output ARREADY, RDATA, RRESP, RID, RLAST, RVALID
   );
endinterface

// File: rtl/axi_rd_arbiter_2to1.sv
// axi_rd_arbiter_2to1: round-robin 2:1 AXI read port sharing with burst length and RID checks
module axi_rd_arbiter_2to1 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   axi_rd_arbiter_2to1_if.slave  s0,
   axi_rd_arbiter_2to1_if.slave  s1,
   axi_rd_arbiter_2to1_if.master m,
   output logic                  gnt,
   output logic                  busy,
   output logic                  err_len,
   output logic                  err_rid
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t                state_q, state_d;
   logic                  gnt_q, gnt_d, last_gnt_q, last_gnt_d;
   logic                  err_len_q, err_len_d, err_rid_q, err_rid_d;
   logic [3:0]            len_q, len_d, cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  win, r_hs;
   assign win  = (s0.ARVALID & s1.ARVALID) ? ~last_gnt_q : s1.ARVALID;
   assign r_hs = m.RVALID & m.RREADY;
   // state and burst bookkeeping registers; last_gnt resets to 1 so s0 wins the first tie
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         last_gnt_q <= 1'b1;
         len_q      <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         err_len_q  <= 1'b0;
         err_rid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         len_q      <= len_d;
         id_q       <= id_d;
         cnt_q      <= cnt_d;
         err_len_q  <= err_len_d;
         err_rid_q  <= err_rid_d;
      end
   end
   // arbitration in IDLE, AR hand-off in ADDR, beat counting and checks in DATA
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      len_d      = len_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      err_len_d  = 1'b0;
      err_rid_d  = 1'b0;
      case (state_q)
         IDLE: if (s0.ARVALID | s1.ARVALID) begin
            gnt_d   = win;
            len_d   = win ? s1.ARLEN : s0.ARLEN;
            id_d    = win ? s1.ARID : s0.ARID;
            cnt_d   = '0;
            state_d = ADDR;
         end
         ADDR: if (m.ARVALID & m.ARREADY) state_d = DATA;
         DATA: if (r_hs) begin
            cnt_d     = cnt_q + 4'd1;
            err_rid_d = m.RID != id_q;
            if (m.RLAST) begin
               err_len_d  = cnt_q != len_q;
               last_gnt_d = gnt_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign araddr    = gnt_q ? s1.ARADDR : s0.ARADDR;
   assign m.ARADDR  = araddr;
   assign m.ARLEN   = gnt_q ? s1.ARLEN : s0.ARLEN;
   assign m.ARSIZE  = gnt_q ? s1.ARSIZE : s0.ARSIZE;
   assign m.ARBURST = gnt_q ? s1.ARBURST : s0.ARBURST;
   assign m.ARID    = gnt_q ? s1.ARID : s0.ARID;
   assign m.ARVALID = (state_q == ADDR) & (gnt_q ? s1.ARVALID : s0.ARVALID);
   assign s0.ARREADY = (state_q == ADDR) & ~gnt_q & m.ARREADY;
   assign s1.ARREADY = (state_q == ADDR) & gnt_q & m.ARREADY;
   assign rdata     = m.RDATA;
   assign s0.RDATA  = rdata;
   assign s1.RDATA  = rdata;
   assign s0.RRESP  = m.RRESP;
   assign s1.RRESP  = m.RRESP;
   assign s0.RID    = m.RID;
   assign s1.RID    = m.RID;
   assign s0.RLAST  = m.RLAST;
   assign s1.RLAST  = m.RLAST;
   assign s0.RVALID = (state_q == DATA) & ~gnt_q & m.RVALID;
   assign s1.RVALID = (state_q == DATA) & gnt_q & m.RVALID;
   assign m.RREADY  = (state_q == DATA) & (gnt_q ? s1.RREADY : s0.RREADY);
   assign gnt     = gnt_q;
   assign busy    = state_q != IDLE;
   assign err_len = err_len_q;
   assign err_rid = err_rid_q;
endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// tb_axi_rd_arbiter_2to1: scoreboard bench for the 2:1 AXI read arbiter
module tb_axi_rd_arbiter_2to1;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int IW = 4;
   typedef struct packed {logic g; logic [AW-1:0] a; logic [3:0] l; logic [IW-1:0] id;} ar_t;
   typedef struct packed {logic [DW-1:0] d; logic [IW-1:0] id; logic last;} r_t;
   logic ACLK = 1'b0;
   logic ARESETn;
   logic gnt, busy, err_len, err_rid;
   ar_t ar_q[$];
   r_t r0_q[$], r1_q[$];
   ar_t ea;
   r_t er;
   int checks = 0, fails = 0;
   int ar_cnt = 0, srv_cnt = 0, elen_cnt = 0, erid_cnt = 0;
   int e0, r0;
   logic [IW-1:0] ar_id_seen = '0;
   bit bp_done, ho_done, held;
   axi_rd_arbiter_2to1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) s0 (), s1 (), m ();
   axi_rd_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .s0(s0), .s1(s1), .m(m),
      .gnt(gnt), .busy(busy), .err_len(err_len), .err_rid(err_rid)
   );
   always #5 ACLK = ~ACLK;
   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction
   function automatic void fail_to(string name);
      checks++;
      fails++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endfunction
   function automatic void exp_ar(bit g, logic [AW-1:0] a, logic [3:0] l, logic [IW-1:0] id);
      ar_q.push_back({g, a, l, id});
   endfunction
   function automatic void exp_r(bit p, logic [DW-1:0] d, logic [IW-1:0] id, bit last);
      if (p) r1_q.push_back({d, id, last});
      else r0_q.push_back({d, id, last});
   endfunction
   // monitor: pops the scoreboard on every AR and R handshake, counts error pulse cycles
   always @(negedge ACLK) begin
      if (m.ARVALID && m.ARREADY) begin
         ar_cnt++;
         ar_id_seen = m.ARID;
         if (ar_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL ar_unexpected: got AR addr %0h with nothing expected", m.ARADDR);
         end else begin
            ea = ar_q.pop_front();
            chk("ar", {gnt, m.ARADDR, m.ARLEN, m.ARID}, ea);
         end
      end
      if (s0.RVALID && s0.RREADY) begin
         if (r0_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL r0_unexpected: got beat %0h with nothing expected", s0.RDATA);
         end else begin
            er = r0_q.pop_front();
            chk("r0", {s0.RDATA, s0.RID, s0.RLAST}, er);
         end
      end
      if (s1.RVALID && s1.RREADY) begin
         if (r1_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL r1_unexpected: got beat %0h with nothing expected", s1.RDATA);
         end else begin
            er = r1_q.pop_front();
            chk("r1", {s1.RDATA, s1.RID, s1.RLAST}, er);
         end
      end
      if (err_len) elen_cnt++;
      if (err_rid) erid_cnt++;
   end
   task automatic ar_req(input bit p, input logic [AW-1:0] a, input logic [3:0] l, input logic [IW-1:0] id);
      bit ok;
      ok = 0;
      if (p) begin
         s1.ARADDR = a; s1.ARLEN = l; s1.ARID = id; s1.ARVALID = 1'b1;
      end else begin
         s0.ARADDR = a; s0.ARLEN = l; s0.ARID = id; s0.ARVALID = 1'b1;
      end
      for (int k = 0; k < 200; k++) begin
         @(negedge ACLK);
         if (p ? (s1.ARREADY === 1'b1) : (s0.ARREADY === 1'b1)) begin ok = 1; break; end
      end
      if (!ok) fail_to("ar_ready_wait");
      @(posedge ACLK); #1;
      if (p) s1.ARVALID = 1'b0;
      else s0.ARVALID = 1'b0;
   endtask
   task automatic serve(input int n, input logic [DW-1:0] base, input bit force_id, input logic [IW-1:0] rid, input int stop);
      bit ok;
      logic [IW-1:0] id;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         if (ar_cnt > srv_cnt) begin ok = 1; break; end
         @(negedge ACLK); #1;
      end
      if (!ok) begin fail_to("slave_ar_wait"); return; end
      srv_cnt++;
      id = force_id ? rid : ar_id_seen;
      @(posedge ACLK); #1;
      for (int i = 0; i < n; i++) begin
         m.RDATA = base + DW'(i); m.RID = id; m.RLAST = (i == n - 1); m.RRESP = 2'b00; m.RVALID = 1'b1;
         if (i == stop) return;
         ok = 0;
         for (int k = 0; k < 200; k++) begin
            @(negedge ACLK);
            if (m.RREADY === 1'b1) begin ok = 1; break; end
         end
         if (!ok) fail_to("slave_rready_wait");
         @(posedge ACLK); #1;
      end
      m.RVALID = 1'b0; m.RLAST = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
   initial begin
      ARESETn = 1'b0;
      s0.ARVALID = 0; s0.ARADDR = '0; s0.ARLEN = '0; s0.ARID = '0; s0.ARSIZE = 3'd2; s0.ARBURST = 2'b01; s0.RREADY = 1;
      s1.ARVALID = 0; s1.ARADDR = '0; s1.ARLEN = '0; s1.ARID = '0; s1.ARSIZE = 3'd2; s1.ARBURST = 2'b01; s1.RREADY = 1;
      m.ARREADY = 1; m.RVALID = 0; m.RLAST = 0; m.RDATA = '0; m.RID = '0; m.RRESP = '0;
      repeat (2) @(posedge ACLK);
      #1;
      chk("reset_state", {busy, gnt, err_len, err_rid, m.ARVALID, m.RREADY, s0.ARREADY, s1.ARREADY, s0.RVALID, s1.RVALID}, 0);
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      exp_ar(0, 32'h2000, 0, 3); exp_ar(1, 32'h3000, 0, 4);
      exp_r(0, 32'hB0, 3, 1); exp_r(1, 32'hC0, 4, 1);
      fork
         ar_req(0, 32'h2000, 0, 3);
         ar_req(1, 32'h3000, 0, 4);
         begin
            serve(1, 32'hB0, 0, 0, 99);
            @(negedge ACLK) chk("bubble_idle", {busy, m.ARVALID}, 0);
            @(negedge ACLK) chk("bubble_addr", {busy, m.ARVALID, gnt}, 3'b111);
            serve(1, 32'hC0, 0, 0, 99);
         end
      join
      @(posedge ACLK); #1;
      exp_ar(0, 32'h2100, 0, 3); exp_ar(1, 32'h3100, 0, 4);
      exp_r(0, 32'hB1, 3, 1); exp_r(1, 32'hC1, 4, 1);
      fork
         ar_req(0, 32'h2100, 0, 3);
         ar_req(1, 32'h3100, 0, 4);
         begin
            serve(1, 32'hB1, 0, 0, 99);
            serve(1, 32'hC1, 0, 0, 99);
         end
      join
      @(posedge ACLK); #1;
      exp_ar(0, 32'h1000, 3, 2);
      for (int i = 0; i < 4; i++) exp_r(0, 32'hA0 + i, 2, i == 3);
      fork
         ar_req(0, 32'h1000, 3, 2);
         serve(4, 32'hA0, 0, 0, 99);
         begin
            @(negedge ACLK) chk("ar_lat_idle", m.ARVALID, 0);
            @(negedge ACLK) chk("ar_lat_addr", {m.ARVALID, m.ARADDR}, {1'b1, 32'h1000});
         end
      join
      @(negedge ACLK) chk("busy_after_last", busy, 0);
      @(posedge ACLK); #1;
      exp_ar(1, 32'h4000, 3, 6);
      for (int i = 0; i < 4; i++) exp_r(1, 32'hD0 + i, 6, i == 3);
      bp_done = 0; held = 0;
      fork
         ar_req(1, 32'h4000, 3, 6);
         begin serve(4, 32'hD0, 0, 0, 99); bp_done = 1; end
         while (!bp_done) begin @(posedge ACLK); #1; s1.RREADY = ~s1.RREADY; end
         while (!bp_done) begin
            @(negedge ACLK);
            if (held) chk("rlast_no_hs_busy", busy, 1);
            if (s1.RVALID) chk("rready_mirror", m.RREADY, s1.RREADY);
            held = s1.RVALID && m.RLAST && !m.RREADY;
         end
      join
      s1.RREADY = 1;
      chk("no_err_yet", {elen_cnt, erid_cnt}, 0);
      @(posedge ACLK); #1;
      exp_ar(0, 32'h5000, 3, 7); exp_ar(1, 32'h6000, 0, 8);
      for (int i = 0; i < 4; i++) exp_r(0, 32'hE0 + i, 7, i == 3);
      exp_r(1, 32'hF0, 8, 1);
      ho_done = 0;
      fork
         ar_req(0, 32'h5000, 3, 7);
         begin serve(4, 32'hE0, 0, 0, 99); ho_done = 1; serve(1, 32'hF0, 0, 0, 99); end
         begin repeat (3) @(posedge ACLK); #1; ar_req(1, 32'h6000, 0, 8); end
         begin
            while (!ho_done) begin
               @(negedge ACLK);
               if (s1.ARVALID) chk("holdoff", {s1.ARREADY, m.ARVALID}, 0);
            end
            @(negedge ACLK) chk("holdoff_addr", {busy, m.ARVALID, gnt}, 3'b111);
         end
      join
      @(posedge ACLK); #1;
      e0 = elen_cnt; r0 = erid_cnt;
      exp_ar(0, 32'h7000, 3, 1);
      exp_r(0, 32'h10, 1, 0); exp_r(0, 32'h11, 1, 1);
      fork
         ar_req(0, 32'h7000, 3, 1);
         serve(2, 32'h10, 0, 0, 99);
      join
      repeat (2) @(negedge ACLK);
      #1;
      chk("err_len_once", elen_cnt - e0, 1);
      chk("err_len_no_rid", erid_cnt - r0, 0);
      chk("err_len_idle", busy, 0);
      e0 = elen_cnt; r0 = erid_cnt;
      exp_ar(0, 32'h7100, 0, 1);
      exp_r(0, 32'h20, 5, 1);
      fork
         ar_req(0, 32'h7100, 0, 1);
         serve(1, 32'h20, 1, 5, 99);
      join
      repeat (2) @(negedge ACLK);
      #1;
      chk("err_rid_once", erid_cnt - r0, 1);
      chk("err_rid_no_len", elen_cnt - e0, 0);
      @(posedge ACLK); #1;
      exp_ar(1, 32'h8000, 3, 9);
      exp_r(1, 32'h30, 9, 0);
      fork
         ar_req(1, 32'h8000, 3, 9);
         serve(4, 32'h30, 0, 0, 1);
      join
      #2;
      ARESETn = 1'b0;
      #1;
      chk("rst_async", {m.ARVALID, m.RREADY, s0.ARREADY, s1.ARREADY, s0.RVALID, s1.RVALID, busy, gnt, err_len, err_rid}, 0);
      m.RVALID = 0; m.RLAST = 0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      exp_ar(0, 32'h9000, 0, 10); exp_ar(1, 32'h9100, 0, 11);
      exp_r(0, 32'h40, 10, 1); exp_r(1, 32'h41, 11, 1);
      fork
         ar_req(0, 32'h9000, 0, 10);
         ar_req(1, 32'h9100, 0, 11);
         begin serve(1, 32'h40, 0, 0, 99); serve(1, 32'h41, 0, 0, 99); end
      join
      repeat (3) @(negedge ACLK);
      chk("ar_q_empty", ar_q.size(), 0);
      chk("r0_q_empty", r0_q.size(), 0);
      chk("r1_q_empty", r1_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/axi_rd_arbiter_2to1.md
Name: axi_rd_arbiter_2to1

Overview:
- Shares one AXI read port (AR + R channels) between two AXI read masters.
- s0 is the I-cache refill path (cache2axi); s1 is the data-side SRAM bridge (srambus2axi). The block replaces their two separate read ports with a single one toward the interconnect/memory.
- Arbitration is round-robin with a single outstanding burst. The grant is held from AR acceptance until the R beat carrying RLAST.
- Also checks burst length and RID, and reports violations as one-cycle error pulses.

Parameters:
- DATA_WIDTH, 32, R data width.
- ADDR_WIDTH, 32, AR address width.
- ID_WIDTH, 4, ARID/RID width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- s0_ARADDR/ARLEN/ARSIZE/ARBURST/ARID  in  ADDR_WIDTH/4/3/2/ID_WIDTH  requester 0 AR fields.
- s0_ARVALID  in  1  requester 0 AR valid.
- s0_ARREADY  out  1  requester 0 AR ready.
- s0_RDATA/RRESP/RID  out  DATA_WIDTH/2/ID_WIDTH  requester 0 R fields.
- s0_RLAST, s0_RVALID  out  1 each  requester 0 R last, R valid.
- s0_RREADY  in  1  requester 0 R ready.
- s1_*  same set as s0_*  requester 1.
- m_ARADDR/ARLEN/ARSIZE/ARBURST/ARID  out  ADDR_WIDTH/4/3/2/ID_WIDTH  shared AR fields.
- m_ARVALID  out  1  shared AR valid.
- m_ARREADY  in  1  shared AR ready.
- m_RDATA/RRESP/RID  in  DATA_WIDTH/2/ID_WIDTH  shared R fields.
- m_RLAST, m_RVALID  in  1 each  shared R last, R valid.
- m_RREADY  out  1  shared R ready.
- gnt  out  1  current/last owner (0 = s0, 1 = s1).
- busy  out  1  high in ADDR or DATA state.
- err_len  out  1  one-cycle pulse: RLAST beat count mismatch.
- err_rid  out  1  one-cycle pulse: RID differs from latched ARID.

Behaviour:
- Reset values (asynchronous): state = IDLE, gnt = 0, last_gnt = 1 (so s0 wins first), beat_cnt = 0, err_len = 0, err_rid = 0.
- Outputs inactive in IDLE and at reset: m_ARVALID, m_RREADY, s*_ARREADY, s*_RVALID all 0. m_AR* and s*_R* data fields carry don't-care values; drive them from the mux as is.
- IDLE state:
  - No request: stay in IDLE.
  - Exactly one sX_ARVALID: gnt <= X.
  - Both valid: gnt <= ~last_gnt (round-robin).
  - Any request: latch the winner's ARLEN and ARID, beat_cnt <= 0, go to ADDR.
  - The decision is registered, so sX_ARVALID to m_ARVALID latency is 1 cycle.
- ADDR state:
  - m_AR* = s[gnt]_AR*; m_ARVALID = s[gnt]_ARVALID; s[gnt]_ARREADY = m_ARREADY; s[~gnt]_ARREADY = 0.
  - On m_ARVALID & m_ARREADY: go to DATA.
  - Requesters obey AXI (valid held until ready), so m_ARVALID does not drop in this state.
- DATA state:
  - s[gnt]_R* = m_R*; s[gnt]_RVALID = m_RVALID; m_RREADY = s[gnt]_RREADY. s[~gnt]_RVALID = 0. All s*_ARREADY = 0.
  - Each beat handshake: beat_cnt <= beat_cnt + 1 (4-bit, wraps).
  - Last beat (beat with RLAST): last_gnt <= gnt, go to IDLE.
- Error checks:
  - err_len pulses on the cycle after the last beat if beat_cnt at that beat != latched ARLEN (ARLEN = 0 means 1 beat).
  - err_rid pulses on the cycle after any beat whose RID != latched ARID.
  - Errors never alter routing; R is always steered by gnt, never by RID.
- Back-to-back bursts:
  - A new grant is evaluated in the IDLE cycle after the RLAST beat, so the minimum bubble between bursts is 1 cycle.
  - A requester waiting in IDLE is guaranteed service within one foreign burst.
- Simultaneous events:
  - A requester may raise ARVALID while the other is in DATA; it is held off (ARREADY = 0) until arbitration.
  - RLAST arriving with RREADY = 0 does not complete the burst; completion requires the handshake.
- Reset mid-burst: state returns to IDLE immediately. The outstanding burst is abandoned; the system resets the slave with the same ARESETn.
- busy = (state != IDLE). gnt is stable for the whole ADDR and DATA period.

Test Plan:
- Solo s0: s0 ARADDR = 0x1000, ARLEN = 3, slave returns 4 beats 0xA0..0xA3 with RLAST on the 4th → m_ARADDR = 0x1000 one cycle after ARVALID; s0 receives 4 beats in order; s1_RVALID stays 0; err_len = 0; busy falls after the RLAST beat.
- Contention: s0 and s1 raise ARVALID in the same cycle from reset → s0 granted first (1-beat burst). Then s1 is granted with a 1-idle-cycle bubble. A second simultaneous request is then granted to s0 (alternation).
- Backpressure: s1 RREADY toggles 1,0,1,0 during a 4-beat burst, slave holds RVALID → m_RREADY mirrors s1_RREADY; no beats lost or duplicated; burst completes only on a handshaked RLAST.
- Hold-off: s1 requests during s0's DATA phase → s1_ARREADY = 0 throughout; m_ARVALID = 0 until s0's RLAST; s1's AR issued 1 cycle after IDLE.
- Errors: ARLEN = 3 but slave asserts RLAST on beat 2 → err_len pulses once, FSM returns to IDLE. A beat with RID = 5 against ARID = 1 → err_rid pulses once.
- Reset mid-burst: ARESETn = 0 after beat 1 of 4 → all valids/readies 0 asynchronously. After release, FSM is in IDLE and the next request is granted to s0.
